// File: rtl/sync_fifo_p.sv
// rtl/sync_fifo_p.sv - single-clock FIFO with occupancy flags and sticky error flags
module sync_fifo_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_acc, rd_acc;

    // A write into a full FIFO is legal when the same edge pops a word.
    always_comb begin
        wr_acc   = wr_en & (~full_q | rd_en);
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
        else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;

        full_d   = (count_d == FULL_LVL);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_LVL);
        aempty_d = (count_d <= AE_LVL);

        // A new error outranks a coincident clear.
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr_en && full_q && !rd_en) ovf_d = 1'b1;
        if (rd_en && empty_q)          unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= (AFULL_TH == 0);
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_p.sv
// tb/tb_sync_fifo_p.sv - directed self-checking bench for sync_fifo_p
module tb_sync_fifo_p;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_p dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one clock of stimulus and return just after the edge.
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ce);
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_p = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        @(negedge clk);
        reset_p = 1'b0;

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), (i >= 12) ? 1 : 0);
            check("fill_full", 32'(full), (i == 16) ? 1 : 0);
            check("fill_aempty", 32'(almost_empty), (i <= 4) ? 1 : 0);
        end
        check("fill_ovf", 32'(overflow), 0);

        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);

        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_valid", 32'(rd_valid), 1);
            check("drain_data", 32'(rd_data), 32'(i));
        end
        check("drain_empty", 32'(empty), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("idle_valid", 32'(rd_valid), 0);
        check("idle_hold", 32'(rd_data), 32'h10);

        // Simultaneous read+write while empty
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("unf_set", 32'(underflow), 1);
        check("unf_no_valid", 32'(rd_valid), 0);
        check("unf_count", 32'(count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_read_valid", 32'(rd_valid), 1);
        check("unf_read_data", 32'(rd_data), 32'h55);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 0);
        check("clr_unf", 32'(underflow), 0);

        // Wrap-around in groups of three
        begin
            int v = 0;
            int exp_v = 0;
            while (v < 40) begin
                int n = (40 - v < 3) ? 40 - v : 3;
                for (int k = 0; k < n; k++) begin
                    step(1'b1, 8'(v), 1'b0, 1'b0);
                    v++;
                    check("wrap_cnt_max", 32'(count <= 5'd3), 1);
                    check("wrap_aempty", 32'(almost_empty), 1);
                end
                for (int k = 0; k < n; k++) begin
                    step(1'b0, 8'h00, 1'b1, 1'b0);
                    check("wrap_valid", 32'(rd_valid), 1);
                    check("wrap_data", 32'(rd_data), 32'(exp_v));
                    exp_v++;
                end
            end
            check("wrap_empty", 32'(empty), 1);
        end

        // Read+write while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(100 + i), 1'b0, 1'b0);
        check("full2_full", 32'(full), 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(200 + i), 1'b1, 1'b0);
            check("rw_full_count", 32'(count), 16);
            check("rw_full_full", 32'(full), 1);
            check("rw_full_valid", 32'(rd_valid), 1);
            check("rw_full_data", 32'(rd_data), 32'(100 + i));
        end
        check("rw_full_ovf", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("rw_full_drain", 32'(rd_data), (i < 11) ? 32'(105 + i) : 32'(200 + i - 11));
        end
        check("rw_full_empty", 32'(empty), 1);

        // Mid-burst reset at count 7 with an underflow pending
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_unf", 32'(underflow), 1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(48 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_count", 32'(count), 7);
        check("pre_rst_valid", 32'(rd_valid), 1);
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        reset_p = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_valid", 32'(rd_valid), 0);
        check("mid_rst_aempty", 32'(almost_empty), 1);
        check("mid_rst_unf", 32'(underflow), 0);
        @(negedge clk);
        reset_p = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_valid", 32'(rd_valid), 1);
        check("post_rst_data", 32'(rd_data), 32'h77);

        // Overflow clear, then clear coinciding with a new overflow
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf2_set", 32'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf2_clr", 32'(overflow), 0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("ovf2_set_wins", 32'(overflow), 1);
        check("ovf2_count", 32'(count), 16);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("ovf2_data_kept", 32'(rd_data), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
